// File: rtl/mac_job_scheduler.sv
// mac_job_scheduler
//   Shares one bias/multiply-accumulate datapath among NUM_REQ requesters.
//   A round-robin arbiter accepts one job, registers its index on sel (which
//   steers the external i/k/b/o stream muxes) and sequences the datapath:
//   one bias load, TAPS joint i/k accumulate beats, then the result handshake.
//
//   Optional stall watchdog: define MAC_JOB_SCHEDULER_TIMEOUT_EN to abort a
//   job that makes no progress for TIMEOUT cycles (err pulses for one cycle).
//   Without the macro err is tied low and the scheduler waits indefinitely.
//
// Ports
//   clk, reset           clock, asynchronous active-high reset
//   req_valid[NUM_REQ]   level job request per requester, held until accepted
//   req_taps             tap count per requester, slice r at [r*TAP_W +: TAP_W]
//   req_ready[NUM_REQ]   one-hot acceptance pulse
//   sel                  registered grant index
//   busy                 high from acceptance until result handshake
//   b_TVALID/b_TREADY    bias stream handshake
//   i_TVALID/i_TREADY    input stream handshake (joint with kernel)
//   k_TVALID/k_TREADY    kernel stream handshake (joint with input)
//   o_TVALID/o_TREADY    result handshake
//   bias_load, acc_en    datapath controls
//   err                  stall-abort pulse
module mac_job_scheduler #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned TAP_W   = 8,
   parameter int unsigned SEL_W   = $clog2(NUM_REQ),
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*TAP_W-1:0] req_taps,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic [SEL_W-1:0]         sel,
   output logic                     busy,
   input  logic                     b_TVALID,
   output logic                     b_TREADY,
   input  logic                     i_TVALID,
   output logic                     i_TREADY,
   input  logic                     k_TVALID,
   output logic                     k_TREADY,
   output logic                     o_TVALID,
   input  logic                     o_TREADY,
   output logic                     bias_load,
   output logic                     acc_en,
   output logic                     err
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BIAS = 2'd1;
   localparam logic [1:0] S_ACC  = 2'd2;
   localparam logic [1:0] S_OUT  = 2'd3;

   logic [1:0]       state;
   logic [SEL_W-1:0] rr;
   logic [TAP_W-1:0] cnt;

   logic             gnt_found;
   logic [SEL_W-1:0] gnt_idx;
   logic [SEL_W:0]   cand_sum;
   logic [SEL_W-1:0] sel_next;
   logic             beat;
   logic             abort;

   // First requester at or after rr, wrapping modulo NUM_REQ.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand_sum  = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         cand_sum = {1'b0, rr} + (SEL_W+1)'(i);
         if (cand_sum >= (SEL_W+1)'(NUM_REQ))
            cand_sum = cand_sum - (SEL_W+1)'(NUM_REQ);
         if (!gnt_found && req_valid[cand_sum[SEL_W-1:0]]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand_sum[SEL_W-1:0];
         end
      end
   end

   assign sel_next = (sel == SEL_W'(NUM_REQ-1)) ? '0 : sel + SEL_W'(1);
   assign beat     = i_TVALID && k_TVALID;

   // Acceptance is also masked by reset so every output reads 0 while it is held.
   always_comb begin
      req_ready = '0;
      if (state == S_IDLE && gnt_found && !reset)
         req_ready[gnt_idx] = 1'b1;
   end

   assign busy      = (state != S_IDLE);
   assign b_TREADY  = (state == S_BIAS);
   assign bias_load = (state == S_BIAS) && b_TVALID;
   assign i_TREADY  = (state == S_ACC) && k_TVALID;
   assign k_TREADY  = (state == S_ACC) && i_TVALID;
   assign acc_en    = (state == S_ACC) && beat;
   assign o_TVALID  = (state == S_OUT);

`ifdef MAC_JOB_SCHEDULER_TIMEOUT_EN
   localparam int unsigned ST_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

   logic [ST_W-1:0] stall;
   logic            progress;

   assign progress = ((state == S_BIAS) && b_TVALID) ||
                     ((state == S_ACC)  && beat)     ||
                     ((state == S_OUT)  && o_TREADY);

   // stall holds the number of earlier idle cycles; the TIMEOUT-th one aborts.
   assign abort = busy && !progress && (stall == ST_W'(TIMEOUT-1));
   assign err   = abort;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         stall <= '0;
      else if (!busy || progress || abort)
         stall <= '0;
      else
         stall <= stall + ST_W'(1);
   end
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT != 0);
   assign abort          = 1'b0;
   assign err            = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
         rr    <= '0;
         sel   <= '0;
         cnt   <= '0;
      end else if (abort) begin
         state <= S_IDLE;
         rr    <= sel_next;
      end else begin
         case (state)
            S_IDLE: begin
               if (gnt_found) begin
                  sel   <= gnt_idx;
                  cnt   <= req_taps[gnt_idx*TAP_W +: TAP_W];
                  state <= S_BIAS;
               end
            end
            S_BIAS: begin
               if (b_TVALID)
                  state <= (cnt != '0) ? S_ACC : S_OUT;
            end
            S_ACC: begin
               if (beat) begin
                  cnt <= cnt - TAP_W'(1);
                  if (cnt == TAP_W'(1))
                     state <= S_OUT;
               end
            end
            default: begin
               if (o_TREADY) begin
                  rr    <= sel_next;
                  state <= S_IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mac_job_scheduler.sv
module tb_mac_job_scheduler;
   localparam int NUM_REQ = 4;
   localparam int TAP_W   = 8;
   localparam int SEL_W   = 2;
`ifdef MAC_JOB_SCHEDULER_TIMEOUT_EN
   localparam int TMO = 8;
`else
   localparam int TMO = 255;
`endif

   logic                     clk;
   logic                     reset;
   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ*TAP_W-1:0] req_taps;
   logic [NUM_REQ-1:0]       req_ready;
   logic [SEL_W-1:0]         sel;
   logic                     busy;
   logic                     b_TVALID, b_TREADY;
   logic                     i_TVALID, i_TREADY;
   logic                     k_TVALID, k_TREADY;
   logic                     o_TVALID, o_TREADY;
   logic                     bias_load, acc_en, err;

   mac_job_scheduler #(
      .NUM_REQ (NUM_REQ),
      .TAP_W   (TAP_W),
      .SEL_W   (SEL_W),
      .TIMEOUT (TMO)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_taps  (req_taps),
      .req_ready (req_ready),
      .sel       (sel),
      .busy      (busy),
      .b_TVALID  (b_TVALID),
      .b_TREADY  (b_TREADY),
      .i_TVALID  (i_TVALID),
      .i_TREADY  (i_TREADY),
      .k_TVALID  (k_TVALID),
      .k_TREADY  (k_TREADY),
      .o_TVALID  (o_TVALID),
      .o_TREADY  (o_TREADY),
      .bias_load (bias_load),
      .acc_en    (acc_en),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests_run    = 0;
   int tests_failed = 0;

   int               pend   [NUM_REQ];
   logic [TAP_W-1:0] taps_v [NUM_REQ];

   int exp_grant[$];
   int exp_acc[$];
   int obs_grant[$], obs_gnt_cyc[$];
   int obs_sel[$], obs_acc[$], obs_bias[$], obs_hs_cyc[$];

   int cyc = 0;
   int acc_run, bias_run, ov_run, ik_seen, err_seen, sel_glitch, acc_state_cyc;
   int bias_cyc, ofirst_cyc;
   logic [SEL_W-1:0] cur_grant;

   // One clock: present requests, observe settled outputs, advance past the edge.
   task automatic tick();
      for (int r = 0; r < NUM_REQ; r++) begin
         req_valid[r] = (pend[r] > 0);
         req_taps[r*TAP_W +: TAP_W] = taps_v[r];
      end
      #1;
      if (req_ready != '0) begin
         for (int r = 0; r < NUM_REQ; r++)
            if (req_ready[r]) begin
               obs_grant.push_back(r);
               obs_gnt_cyc.push_back(cyc);
               if (pend[r] > 0) pend[r]--;
               cur_grant = SEL_W'(r);
            end
         acc_run = 0; bias_run = 0; ov_run = 0; ik_seen = 0; acc_state_cyc = 0;
         bias_cyc = -1; ofirst_cyc = -1;
      end
      if (busy && sel !== cur_grant) sel_glitch++;
      if (bias_load) begin bias_run++; bias_cyc = cyc; end
      if (acc_en) acc_run++;
      if (i_TREADY || k_TREADY) ik_seen++;
      if (busy && !b_TREADY && !o_TVALID) acc_state_cyc++;
      if (o_TVALID) begin
         if (ov_run == 0) ofirst_cyc = cyc;
         ov_run++;
      end
      if (err) err_seen++;
      if (o_TVALID && o_TREADY) begin
         obs_sel.push_back(int'(sel));
         obs_acc.push_back(acc_run);
         obs_bias.push_back(bias_run);
         obs_hs_cyc.push_back(cyc);
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic clear_sb();
      exp_grant.delete(); exp_acc.delete();
      obs_grant.delete(); obs_gnt_cyc.delete();
      obs_sel.delete(); obs_acc.delete(); obs_bias.delete(); obs_hs_cyc.delete();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      for (int r = 0; r < NUM_REQ; r++) begin pend[r] = 0; taps_v[r] = '0; end
      req_valid = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      cur_grant = '0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      req_valid = '1; req_taps = '0;
      b_TVALID = 1'b1; i_TVALID = 1'b1; k_TVALID = 1'b1; o_TREADY = 1'b1;
      @(posedge clk);
      #1;
      tests_run++;
      if (req_ready !== '0) begin
         tests_failed++;
         $display("FAIL reset_req_ready: got %b expected 0000", req_ready);
      end
      tests_run++;
      if ({sel, busy, b_TREADY, i_TREADY, k_TREADY, o_TVALID, bias_load, acc_en, err} !== '0) begin
         tests_failed++;
         $display("FAIL reset_outputs: sel=%0d busy=%b bT=%b iT=%b kT=%b oV=%b bl=%b ae=%b err=%b expected all 0",
                  sel, busy, b_TREADY, i_TREADY, k_TREADY, o_TVALID, bias_load, acc_en, err);
      end
      do_reset();
      tick();
      tests_run++;
      if (busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL idle_no_request: busy=%b expected 0", busy);
      end
   endtask

   task automatic test_single();
      int g;
      do_reset(); clear_sb();
      b_TVALID = 1; i_TVALID = 1; k_TVALID = 1; o_TREADY = 1;
      taps_v[0] = 3; pend[0] = 1;
      exp_grant.push_back(0); exp_acc.push_back(3);
      tick();
      tests_run++;
      if (b_TREADY !== 1'b1) begin
         tests_failed++;
         $display("FAIL single_latency: b_TREADY=%b one cycle after acceptance, expected 1", b_TREADY);
      end
      for (int c = 0; c < 50 && obs_sel.size() < 1; c++) tick();
      tests_run++;
      if (obs_sel.size() != 1) begin
         tests_failed++;
         $display("FAIL single_done: %0d results expected 1", obs_sel.size());
      end else begin
         g = exp_grant.pop_front();
         tests_run++;
         if (obs_grant[0] !== g || obs_sel[0] !== g) begin
            tests_failed++;
            $display("FAIL single_sel: grant=%0d sel=%0d expected %0d", obs_grant[0], obs_sel[0], g);
         end
         tests_run++;
         if (obs_acc[0] !== exp_acc[0] || obs_bias[0] !== 1) begin
            tests_failed++;
            $display("FAIL single_beats: acc=%0d bias=%0d expected %0d and 1", obs_acc[0], obs_bias[0], exp_acc[0]);
         end
         tests_run++;
         if (ov_run !== 1) begin
            tests_failed++;
            $display("FAIL single_ovalid: o_TVALID cycles=%0d expected 1", ov_run);
         end
      end
      tick();
      tests_run++;
      if (busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL single_idle: busy=%b expected 0", busy);
      end
   endtask

   task automatic test_fairness();
      do_reset(); clear_sb();
      b_TVALID = 1; i_TVALID = 1; k_TVALID = 1; o_TREADY = 1;
      for (int r = 0; r < NUM_REQ; r++) begin taps_v[r] = 1; pend[r] = 1; end
      pend[0] = 2;
      exp_grant = '{0, 1, 2, 3, 0};
      for (int c = 0; c < 200 && obs_sel.size() < 5; c++) tick();
      tests_run++;
      if (obs_sel.size() != 5 || obs_grant.size() != 5) begin
         tests_failed++;
         $display("FAIL fair_done: results=%0d grants=%0d expected 5", obs_sel.size(), obs_grant.size());
      end else begin
         for (int k = 0; k < 5; k++) begin
            tests_run++;
            if (obs_grant[k] !== exp_grant[k] || obs_sel[k] !== exp_grant[k] || obs_acc[k] !== 1) begin
               tests_failed++;
               $display("FAIL fair_job%0d: grant=%0d sel=%0d acc=%0d expected %0d,%0d,1",
                        k, obs_grant[k], obs_sel[k], obs_acc[k], exp_grant[k], exp_grant[k]);
            end
         end
         tests_run++;
         if (obs_gnt_cyc[1] - obs_hs_cyc[0] !== 1) begin
            tests_failed++;
            $display("FAIL fair_gap: handshake-to-accept=%0d cycles expected 1", obs_gnt_cyc[1] - obs_hs_cyc[0]);
         end
      end
   endtask

   task automatic test_backpressure();
      clear_sb();
      b_TVALID = 1; k_TVALID = 1; o_TREADY = 0;
      taps_v[1] = 2; pend[1] = 1;
      exp_grant.push_back(1); exp_acc.push_back(2);
      for (int c = 0; c < 100 && obs_sel.size() < 1; c++) begin
         i_TVALID = ((cyc % 2) != 0);
         o_TREADY = (obs_grant.size() > 0) && (ov_run >= 5);
         tick();
      end
      o_TREADY = 1;
      tests_run++;
      if (obs_sel.size() != 1) begin
         tests_failed++;
         $display("FAIL bp_done: %0d results expected 1", obs_sel.size());
      end else begin
         tests_run++;
         if (obs_sel[0] !== exp_grant[0] || obs_acc[0] !== exp_acc[0]) begin
            tests_failed++;
            $display("FAIL bp_beats: sel=%0d acc=%0d expected %0d and %0d", obs_sel[0], obs_acc[0], exp_grant[0], exp_acc[0]);
         end
         tests_run++;
         if (ov_run !== 6) begin
            tests_failed++;
            $display("FAIL bp_ovalid: o_TVALID cycles=%0d expected 6", ov_run);
         end
      end
      i_TVALID = 1;
   endtask

   task automatic test_taps_zero();
      clear_sb();
      b_TVALID = 1; i_TVALID = 1; k_TVALID = 1; o_TREADY = 1;
      taps_v[2] = 0; pend[2] = 1;
      exp_grant.push_back(2);
      for (int c = 0; c < 50 && obs_sel.size() < 1; c++) tick();
      tests_run++;
      if (obs_sel.size() != 1) begin
         tests_failed++;
         $display("FAIL tz_done: %0d results expected 1", obs_sel.size());
      end else begin
         tests_run++;
         if (obs_sel[0] !== exp_grant[0] || obs_acc[0] !== 0 || obs_bias[0] !== 1) begin
            tests_failed++;
            $display("FAIL tz_beats: sel=%0d acc=%0d bias=%0d expected %0d,0,1", obs_sel[0], obs_acc[0], obs_bias[0], exp_grant[0]);
         end
         tests_run++;
         if (ik_seen !== 0 || ofirst_cyc - bias_cyc !== 1) begin
            tests_failed++;
            $display("FAIL tz_timing: ik_ready_cycles=%0d bias-to-out=%0d expected 0 and 1", ik_seen, ofirst_cyc - bias_cyc);
         end
      end
   endtask

   task automatic test_reset_mid();
      clear_sb();
      b_TVALID = 1; i_TVALID = 1; k_TVALID = 1; o_TREADY = 1;
      taps_v[3] = 4; pend[3] = 1;
      for (int c = 0; c < 50 && !(obs_grant.size() > 0 && acc_run == 1); c++) tick();
      reset = 1'b1;
      #1;
      tests_run++;
      if ({req_ready, sel, busy, acc_en, i_TREADY, k_TREADY, o_TVALID} !== '0) begin
         tests_failed++;
         $display("FAIL midreset_outputs: ready=%b sel=%0d busy=%b acc_en=%b oV=%b expected all 0", req_ready, sel, busy, acc_en, o_TVALID);
      end
      for (int r = 0; r < NUM_REQ; r++) pend[r] = 0;
      req_valid = '0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      tests_run++;
      if (obs_sel.size() != 0 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL midreset_abandon: results=%0d busy=%b expected 0 and 0", obs_sel.size(), busy);
      end
      clear_sb();
      taps_v[1] = 2; taps_v[3] = 2; pend[1] = 1; pend[3] = 1;
      exp_grant = '{1, 3};
      for (int c = 0; c < 100 && obs_sel.size() < 2; c++) tick();
      tests_run++;
      if (obs_sel.size() != 2) begin
         tests_failed++;
         $display("FAIL midreset_done: %0d results expected 2", obs_sel.size());
      end else begin
         for (int k = 0; k < 2; k++) begin
            tests_run++;
            if (obs_sel[k] !== exp_grant[k] || obs_acc[k] !== 2) begin
               tests_failed++;
               $display("FAIL midreset_job%0d: sel=%0d acc=%0d expected %0d and 2", k, obs_sel[k], obs_acc[k], exp_grant[k]);
            end
         end
      end
   endtask

`ifdef MAC_JOB_SCHEDULER_TIMEOUT_EN
   task automatic test_timeout();
      clear_sb();
      err_seen = 0;
      b_TVALID = 1; i_TVALID = 1; k_TVALID = 0; o_TREADY = 1;
      taps_v[0] = 2; pend[0] = 1;
      for (int c = 0; c < 50 && err_seen == 0; c++) tick();
      tests_run++;
      if (err_seen !== 1 || acc_state_cyc !== 8) begin
         tests_failed++;
         $display("FAIL tmo_err: err_cycles=%0d stall_cycles=%0d expected 1 and 8", err_seen, acc_state_cyc);
      end
      tests_run++;
      if (ov_run !== 0 || obs_sel.size() != 0 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL tmo_abort: oV_cycles=%0d results=%0d busy=%b expected 0,0,0", ov_run, obs_sel.size(), busy);
      end
      clear_sb();
      k_TVALID = 1;
      taps_v[0] = 1; taps_v[1] = 1; pend[0] = 1; pend[1] = 1;
      for (int c = 0; c < 50 && obs_sel.size() < 1; c++) tick();
      tests_run++;
      if (obs_sel.size() < 1 || obs_sel[0] !== 1) begin
         tests_failed++;
         $display("FAIL tmo_next: first result sel=%0d (count %0d) expected 1",
                  (obs_sel.size() > 0) ? obs_sel[0] : -1, obs_sel.size());
      end
      for (int c = 0; c < 50 && obs_sel.size() < 2; c++) tick();
   endtask
`else
   task automatic test_no_err();
      tests_run++;
      if (err_seen !== 0) begin
         tests_failed++;
         $display("FAIL err_tied: err cycles=%0d expected 0", err_seen);
      end
   endtask
`endif

   task automatic test_sel_stable();
      tests_run++;
      if (sel_glitch !== 0) begin
         tests_failed++;
         $display("FAIL sel_stable: %0d busy cycles with sel != grant, expected 0", sel_glitch);
      end
   endtask

   initial begin
      reset = 1'b1;
      req_valid = '0; req_taps = '0;
      b_TVALID = 0; i_TVALID = 0; k_TVALID = 0; o_TREADY = 0;
      acc_run = 0; bias_run = 0; ov_run = 0; ik_seen = 0; err_seen = 0;
      sel_glitch = 0; acc_state_cyc = 0; bias_cyc = -1; ofirst_cyc = -1;
      cur_grant = '0;
      for (int r = 0; r < NUM_REQ; r++) begin pend[r] = 0; taps_v[r] = '0; end
      test_reset();
      test_single();
      test_fairness();
      test_backpressure();
      test_taps_zero();
      test_reset_mid();
`ifdef MAC_JOB_SCHEDULER_TIMEOUT_EN
      test_timeout();
`else
      test_no_err();
`endif
      test_sel_stable();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, tests_run=%0d", tests_run);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mac_job_scheduler.md
Name: mac_job_scheduler

Overview:
- Shares one bias/multiply-accumulate datapath among NUM_REQ requesters.
- Each requester posts a job (valid plus tap count). A round-robin arbiter picks one job, drives the external stream mux select, and sequences the datapath through one output: bias load, TAPS accumulate beats, then result handshake.
- Sits above the per-datapath control unit. It replaces direct new_i sequencing when several channels contend for one MAC.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
TAP_W, 8, width of per-job tap count
SEL_W, $clog2(NUM_REQ), width of grant index
TIMEOUT, 255, stall cycles before abort (optional feature only)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  job request per requester, level, held until accepted
req_taps  in  NUM_REQ*TAP_W  tap count per requester, slice r at [r*TAP_W +: TAP_W]
req_ready  out  NUM_REQ  one-hot acceptance pulse, 1 cycle
sel  out  SEL_W  registered grant index, drives external i/k/b/o stream muxes
busy  out  1  high from acceptance until result handshake
b_TVALID  in  1  muxed bias stream valid
b_TREADY  out  1  bias stream ready
i_TVALID  in  1  muxed input stream valid
i_TREADY  out  1  input stream ready
k_TVALID  in  1  muxed kernel stream valid
k_TREADY  out  1  kernel stream ready
o_TVALID  out  1  result valid
o_TREADY  in  1  result ready
bias_load  out  1  datapath: load accumulator with bias this cycle
acc_en  out  1  datapath: accumulate i*k this cycle
err  out  1  abort pulse (0 when feature compiled out)

Behaviour:
- Reset: state IDLE, rr pointer 0, sel 0, tap counter 0. All outputs 0.
- All outputs are decoded from registered state plus the input valids/ready shown below. No output-to-input combinational loop beyond these.
- Reset asserted mid-job: return to IDLE immediately. No o_TVALID, accumulator contents abandoned.
- IDLE:
  - If any req_valid is set, grant the first requester at or after the rr pointer (wrapping modulo NUM_REQ).
  - Same cycle: req_ready[g]=1, latch taps into counter, register sel<=g, go to BIAS.
  - No request: stay in IDLE.
- BIAS:
  - b_TREADY=1, bias_load=b_TVALID.
  - On b_TVALID: go to ACC if taps!=0, else go to OUT.
- ACC:
  - Joint handshake: i_TREADY=k_TVALID, k_TREADY=i_TVALID, acc_en=i_TVALID&k_TVALID.
  - Counter decrements on each joint beat. The beat that takes the counter 1->0 goes to OUT.
  - One-sided valid consumes nothing.
- OUT:
  - o_TVALID=1, held stable until o_TREADY.
  - On o_TREADY: rr pointer<=(sel+1) mod NUM_REQ, go to IDLE.
- busy=1 in BIAS, ACC and OUT.
- Latency: request to b_TREADY is 2 cycles (IDLE accept, then BIAS). Back-to-back jobs have one IDLE cycle between o handshake and next acceptance.
- taps=0: bias passthrough, no i/k beats consumed.
- taps max = 2^TAP_W-1 with no overflow. The counter only decrements.
- A req_valid dropped before acceptance is ignored. A requester is never granted twice while others wait (strict round-robin).
- sel is constant from acceptance through result handshake.

Optional Feature:
- Macro MAC_JOB_SCHEDULER_TIMEOUT_EN.
- With the macro: a stall counter clears on every state change and on every BIAS/ACC/OUT handshake, and increments otherwise in BIAS/ACC/OUT.
  - On reaching TIMEOUT: err=1 for 1 cycle, rr pointer<=sel+1, go to IDLE, no o_TVALID.
- Without the macro: no counter, err tied 0, the scheduler waits indefinitely.

Test Plan:
- Single job: req_valid=4'b0001, taps=3, b/i/k always valid, o_TREADY=1 -> req_ready[0] pulse, 1 bias_load, 3 acc_en, o_TVALID 1 cycle, sel=0 throughout.
- Fairness: all 4 requesters valid, taps=1 each -> grants in order 0,1,2,3,0. Each o handshake carries sel equal to the grant.
- Backpressure: taps=2, i_TVALID toggling while k_TVALID=1, o_TREADY held low 5 cycles -> exactly 2 acc_en, o_TVALID stable 6 cycles, no extra beats.
- taps=0 on requester 2 -> bias_load then o_TVALID next cycle, i_TREADY/k_TREADY never asserted.
- Reset mid-ACC (after 1 of 4 beats) -> outputs 0 next edge, rr pointer 0. Next request from requester 1 is granted cleanly.
- With MAC_JOB_SCHEDULER_TIMEOUT_EN, TIMEOUT=8, k_TVALID held 0 in ACC -> err pulse at stall cycle 8, return to IDLE, no o_TVALID. Next grant goes to sel+1.
